// File: rtl/obi_mem_responder.sv
`default_nettype none
// ------------------------------------------------------------------------
// obi_mem_responder : OBI memory responder with configurable grant wait,
//                     response latency and outstanding-transaction limit.
// Rev 1.0
// ------------------------------------------------------------------------
module obi_mem_responder #(
  parameter int NUM_WORDS       = 1024,
  parameter int GNT_WAIT        = 0,
  parameter int RVALID_LAT      = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int         AW     = $clog2(NUM_WORDS);
  localparam logic [3:0] WAIT_C = 4'(GNT_WAIT);
  localparam logic [3:0] MAX_C  = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_e;

  state_e          state_q;
  logic [3:0]      wait_q;
  logic [3:0]      outst_q, outst_d;
  logic [RVALID_LAT-1:0] vld_q;
  logic [31:0]     data_q [RVALID_LAT];
  logic [31:0]     mem_q  [NUM_WORDS];

  logic [AW-1:0]   word_idx;
  logic            credit;
  logic            unused_addr;

  assign word_idx    = addr_i[AW+1:2];
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

  // A response leaving the pipeline this cycle frees its slot immediately.
  assign credit   = (outst_q - {3'b000, rvalid_o}) < MAX_C;
  assign gnt_o    = req_i & ~rst_i & (wait_q == WAIT_C) & credit;
  assign rvalid_o = vld_q[RVALID_LAT-1] & ~rst_i;
  assign rdata_o  = rvalid_o ? data_q[RVALID_LAT-1] : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else if (!req_i || gnt_o) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT: begin
          if (wait_q == WAIT_C) begin
            state_q <= S_READY;
          end else begin
            wait_q  <= wait_q + 4'd1;
            state_q <= (wait_q + 4'd1 == WAIT_C) ? S_READY : S_WAIT;
          end
        end
        default: state_q <= S_READY;
      endcase
    end
  end

  assign outst_d = outst_q + {3'b000, gnt_o} - {3'b000, rvalid_o};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q <= 4'd0;
      vld_q   <= '0;
    end else begin
      outst_q <= outst_d;
      for (int i = RVALID_LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
      end
      vld_q[0] <= gnt_o;
    end
  end

  // Data needs no reset: it is only visible when its valid bit is set.
  always_ff @(posedge clk_i) begin
    for (int i = RVALID_LAT - 1; i > 0; i--) begin
      data_q[i] <= data_q[i-1];
    end
    data_q[0] <= (gnt_o && !we_i) ? mem_q[word_idx] : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_mem_responder.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_obi_mem_responder : three responder configurations checked against a
//                        transaction-level model plus literal expectations.
// Rev 1.0
// ------------------------------------------------------------------------
module tb_obi_mem_responder;

  localparam int NW  = 1024;
  localparam int GW0 = 0, LT0 = 1, MO0 = 2;
  localparam int GW1 = 3, LT1 = 4, MO1 = 1;
  localparam int GW2 = 0, LT2 = 3, MO2 = 3;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        gnt   [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_mem_responder #(.NUM_WORDS(NW), .GNT_WAIT(GW0), .RVALID_LAT(LT0), .MAX_OUTSTANDING(MO0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]));
  obi_mem_responder #(.NUM_WORDS(NW), .GNT_WAIT(GW1), .RVALID_LAT(LT1), .MAX_OUTSTANDING(MO1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]));
  obi_mem_responder #(.NUM_WORDS(NW), .GNT_WAIT(GW2), .RVALID_LAT(LT2), .MAX_OUTSTANDING(MO2)) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]));

  function automatic int gw_of(int k);
    case (k) 0: return GW0; 1: return GW1; default: return GW2; endcase
  endfunction
  function automatic int lt_of(int k);
    case (k) 0: return LT0; 1: return LT1; default: return LT2; endcase
  endfunction
  function automatic int mo_of(int k);
    case (k) 0: return MO0; 1: return MO1; default: return MO2; endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Transaction-level model: responses are scheduled into a cycle-indexed ring.
  int          cyc = 0;
  bit          dv   [3][16];
  logic [31:0] dd   [3][16];
  logic [31:0] mem_m[3][NW];
  int          infl [3] = '{0, 0, 0};
  int          held [3] = '{0, 0, 0};

  // Observation log used by the literal checks.
  int          gcyc [3][64];
  int          rcyc [3][64];
  logic [31:0] rdat [3][64];
  int          ng   [3] = '{0, 0, 0};
  int          nr   [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit          erv, eg;
      logic [31:0] erd;
      int          slot, slot2, idx;
      slot = cyc % 16;
      erv  = !rst[k] && dv[k][slot];
      erd  = erv ? dd[k][slot] : 32'h0;
      eg   = !rst[k] && req[k] && (held[k] >= gw_of(k)) &&
             ((infl[k] - (erv ? 1 : 0)) < mo_of(k));
      chk("gnt",    k, {31'b0, gnt[k]},    {31'b0, eg});
      chk("rvalid", k, {31'b0, rvalid[k]}, {31'b0, erv});
      chk("rdata",  k, rdata[k], erd);

      if (gnt[k] && ng[k] < 64) begin
        gcyc[k][ng[k]] = cyc;
        ng[k]++;
      end
      if (rvalid[k] && nr[k] < 64) begin
        rcyc[k][nr[k]] = cyc;
        rdat[k][nr[k]] = rdata[k];
        nr[k]++;
      end

      if (rst[k]) begin
        for (int s = 0; s < 16; s++) dv[k][s] = 1'b0;
        infl[k] = 0;
        held[k] = 0;
      end else begin
        if (erv) begin
          dv[k][slot] = 1'b0;
          infl[k]--;
        end
        if (eg) begin
          idx   = int'((addr[k] >> 2) % NW);
          slot2 = (cyc + lt_of(k)) % 16;
          dv[k][slot2] = 1'b1;
          dd[k][slot2] = we[k] ? 32'h0 : mem_m[k][idx];
          if (we[k]) begin
            for (int b = 0; b < 4; b++)
              if (be[k][b]) mem_m[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
          end
          infl[k]++;
          held[k] = 0;
        end else begin
          held[k] = req[k] ? held[k] + 1 : 0;
        end
      end
    end
    cyc++;
  end

  // Holds the request until granted; req stays high on return for back-to-back use.
  task automatic issue(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, output int waited);
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    waited = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (gnt[k]) begin
        waited = n;
        break;
      end
    end
    if (waited < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout inst%0d t=%0t: got no gnt expected gnt", k, $time);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, rb, gb, nr0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      idle(k);
    end
    req[0] = 1'b1;
    @(negedge clk);
    chk("reset_gnt_forced_low", 0, {31'b0, gnt[0]}, 32'h0);
    chk("reset_rvalid", 0, {31'b0, rvalid[0]}, 32'h0);
    chk("reset_rdata", 0, rdata[0], 32'h0);
    cycles(2);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    idle(0);
    cycles(1);

    // Defaults: write then back-to-back read of the same word
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, w);
    chk("k0_wr_same_cycle_gnt", 0, 32'(w), 32'd0);
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, w);
    chk("k0_rd_same_cycle_gnt", 0, 32'(w), 32'd0);
    idle(0);
    cycles(4);
    chk("k0_b2b_grants", 0, 32'(gcyc[0][1] - gcyc[0][0]), 32'd1);
    chk("k0_wr_rvalid_lat", 0, 32'(rcyc[0][0] - gcyc[0][0]), 32'd1);
    chk("k0_wr_rdata_zero", 0, rdat[0][0], 32'h0);
    chk("k0_rd_rvalid_lat", 0, 32'(rcyc[0][1] - gcyc[0][1]), 32'd1);
    chk("k0_rd_data", 0, rdat[0][1], 32'hDEADBEEF);

    // Byte enables, aliasing and the empty byte-enable write
    issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344, w);
    issue(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, w);
    issue(0, 1'b0, 4'hF, 32'h20, 32'h0, w);
    issue(0, 1'b0, 4'hF, 32'h20 + NW * 4, 32'h0, w);
    issue(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, w);
    issue(0, 1'b0, 4'hF, 32'h22, 32'h0, w);
    idle(0);
    cycles(4);
    chk("k0_nresp", 0, 32'(nr[0]), 32'd8);
    chk("k0_be_merge", 0, rdat[0][4], 32'h11BB33DD);
    chk("k0_alias", 0, rdat[0][5], 32'h11BB33DD);
    chk("k0_be_zero_nowrite", 0, rdat[0][7], 32'h11BB33DD);

    // Instance 1: grant wait 3, latency 4, one outstanding
    issue(1, 1'b1, 4'hF, 32'h0, 32'hA0000000, w);
    chk("k1_first_wait", 1, 32'(w), 32'd3);
    issue(1, 1'b1, 4'hF, 32'h4, 32'hA0000001, w);
    issue(1, 1'b1, 4'hF, 32'h8, 32'hA0000002, w);
    issue(1, 1'b1, 4'hF, 32'h40, 32'h00000055, w);
    // abandoned write: dropped before its wait completes
    we[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h99; be[1] = 4'hF;
    cycles(2);
    idle(1);
    cycles(8);
    rb = nr[1];
    gb = ng[1];
    issue(1, 1'b0, 4'hF, 32'h0, 32'h0, w);
    chk("k1_rd_wait", 1, 32'(w), 32'd3);
    issue(1, 1'b0, 4'hF, 32'h4, 32'h0, w);
    chk("k1_rd2_wait", 1, 32'(w), 32'd3);
    issue(1, 1'b0, 4'hF, 32'h8, 32'h0, w);
    issue(1, 1'b0, 4'hF, 32'h40, 32'h0, w);
    idle(1);
    cycles(8);
    chk("k1_gnt_spacing_a", 1, 32'(gcyc[1][gb+1] - gcyc[1][gb]), 32'd4);
    chk("k1_gnt_spacing_b", 1, 32'(gcyc[1][gb+2] - gcyc[1][gb+1]), 32'd4);
    chk("k1_rvalid_lat", 1, 32'(rcyc[1][rb] - gcyc[1][gb]), 32'd4);
    chk("k1_gnt_on_rvalid", 1, 32'(gcyc[1][gb+1] - rcyc[1][rb]), 32'd0);
    chk("k1_rd0", 1, rdat[1][rb],   32'hA0000000);
    chk("k1_rd1", 1, rdat[1][rb+1], 32'hA0000001);
    chk("k1_rd2", 1, rdat[1][rb+2], 32'hA0000002);
    chk("k1_abandon_noeffect", 1, rdat[1][rb+3], 32'h00000055);

    // Instance 2: latency 3, three outstanding, streaming reads
    for (int i = 0; i < 6; i++) issue(2, 1'b1, 4'hF, 32'(i * 4), 32'hC0000000 + 32'(i), w);
    idle(2);
    cycles(6);
    rb = nr[2];
    gb = ng[2];
    for (int i = 0; i < 6; i++) issue(2, 1'b0, 4'hF, 32'(i * 4), 32'h0, w);
    idle(2);
    cycles(6);
    chk("k2_gnt_every_cycle", 2, 32'(gcyc[2][gb+5] - gcyc[2][gb]), 32'd5);
    chk("k2_rvalid_lat", 2, 32'(rcyc[2][rb] - gcyc[2][gb]), 32'd3);
    chk("k2_rvalid_every_cycle", 2, 32'(rcyc[2][rb+5] - rcyc[2][rb]), 32'd5);
    chk("k2_rd0", 2, rdat[2][rb], 32'hC0000000);
    chk("k2_rd5", 2, rdat[2][rb+5], 32'hC0000005);

    // Reset with two reads in flight
    nr0 = nr[2];
    issue(2, 1'b0, 4'hF, 32'h0, 32'h0, w);
    issue(2, 1'b0, 4'hF, 32'h4, 32'h0, w);
    idle(2);
    rst[2] = 1'b1;
    cycles(1);
    rst[2] = 1'b0;
    cycles(8);
    chk("k2_reset_drops_resp", 2, 32'(nr[2] - nr0), 32'd0);
    gb = ng[2];
    issue(2, 1'b0, 4'hF, 32'h8, 32'h0, w);
    chk("k2_post_reset_gnt", 2, 32'(w), 32'd0);
    idle(2);
    cycles(5);
    chk("k2_post_reset_nresp", 2, 32'(nr[2] - nr0), 32'd1);
    chk("k2_post_reset_lat", 2, 32'(rcyc[2][nr0] - gcyc[2][gb]), 32'd3);
    chk("k2_post_reset_data", 2, rdat[2][nr0], 32'hC0000002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
